// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall / flush / forwarding controller for the 5-stage 16-bit
//   pipeline. A small FSM (RUN, LD_STALL, MEM_WAIT) sequences load-use
//   bubbles, taken-branch flushes and multi-cycle data-memory waits. Control
//   outputs are combinational from the FSM state and the current inputs so
//   they act in the same cycle the condition appears.
//
// Parameters
//   LOAD_STALL_CYCLES  : bubbles inserted per load-use hazard (1..7)
//   ZERO_REG_HARDWIRED : 1 -> register 0 never causes a hazard or a forward
//
// Optional build macro
//   HAZARD_PERF_CNT_EN : adds saturating 16-bit counters stall_cycles
//                        (cycles with pc_en=0) and flush_events (cycles
//                        with ifid_flush=1).
//
// Ports
//   clk, rst                       : clock, async active-high reset
//   id_rs/id_rt, id_uses_rs/_rt    : ID-stage sources and their use flags
//   ex_rs/ex_rt/ex_rd              : EX-stage sources and destination
//   ex_reg_write, ex_mem_read      : EX instruction writes / is a load
//   branch_taken                   : branch resolved taken in EX
//   mem_rd, mem_reg_write          : EX/MEM destination and RegWrite
//   mem_req, mem_ready             : data-memory access and completion
//   wb_rd, wb_reg_write            : MEM/WB destination and RegWrite
//   pc_en, ifid_en, exmem_en       : register load enables
//   ifid_flush, idex_flush,
//   memwb_flush                    : bubble insertion controls
//   fwd_a, fwd_b                   : EX operand sources
//                                    (00 regfile, 01 EX/MEM, 10 MEM/WB)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int unsigned LOAD_STALL_CYCLES  = 1,
   parameter bit          ZERO_REG_HARDWIRED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  id_rs,
   input  logic [2:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic [2:0]  ex_rs,
   input  logic [2:0]  ex_rt,
   input  logic [2:0]  ex_rd,
   input  logic        ex_reg_write,
   input  logic        ex_mem_read,
   input  logic        branch_taken,
   input  logic [2:0]  mem_rd,
   input  logic        mem_reg_write,
   input  logic        mem_req,
   input  logic        mem_ready,
   input  logic [2:0]  wb_rd,
   input  logic        wb_reg_write,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        exmem_en,
   output logic        memwb_flush,
`ifdef HAZARD_PERF_CNT_EN
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_events,
`endif
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LD_STALL = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_t;

   localparam bit         MULTI_STALL  = (LOAD_STALL_CYCLES > 1);
   localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

   state_t     state_q, state_d;
   state_t     ret_state_q, ret_state_d;
   state_t     eff_state_s;
   logic [2:0] stall_cnt_q, stall_cnt_d;

   logic hazard_s;
   logic memstall_s;
   logic pc_en_s, ifid_en_s, ifid_flush_s, idex_flush_s, exmem_en_s, memwb_flush_s;
   logic [1:0] fwd_a_s, fwd_b_s;

   // Register number comparison; register 0 optionally never matches.
   function automatic logic reg_match(input logic [2:0] a, input logic [2:0] b);
      return (a == b) && (!ZERO_REG_HARDWIRED || (a != 3'd0));
   endfunction

   // Forwarding source select; the younger EX/MEM result wins a double match.
   function automatic logic [1:0] fwd_sel(input logic [2:0] src);
      logic [1:0] sel;
      if (mem_reg_write && reg_match(src, mem_rd)) begin
         sel = 2'b01;
      end else if (wb_reg_write && reg_match(src, wb_rd)) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   assign hazard_s = ex_mem_read & ex_reg_write &
                     ((id_uses_rs & reg_match(id_rs, ex_rd)) |
                      (id_uses_rt & reg_match(id_rt, ex_rd)));
   assign memstall_s = mem_req & ~mem_ready;

   // Next-state and control decode. On the mem_ready cycle of MEM_WAIT the
   // return state's logic runs directly, so that cycle behaves exactly as a
   // normal cycle of the state being resumed (branch/hazard act there).
   always_comb begin
      state_d       = state_q;
      ret_state_d   = ret_state_q;
      stall_cnt_d   = stall_cnt_q;
      pc_en_s       = 1'b1;
      ifid_en_s     = 1'b1;
      ifid_flush_s  = 1'b0;
      idex_flush_s  = 1'b0;
      exmem_en_s    = 1'b1;
      memwb_flush_s = 1'b0;

      if ((state_q == ST_MEM_WAIT) && mem_ready) begin
         eff_state_s = ret_state_q;
      end else begin
         eff_state_s = state_q;
      end

      case (eff_state_s)
         ST_RUN: begin
            if (memstall_s) begin
               // Freeze everything up to EX/MEM; ID/EX holds because the
               // front end is frozen and no bubble is injected.
               pc_en_s       = 1'b0;
               ifid_en_s     = 1'b0;
               exmem_en_s    = 1'b0;
               memwb_flush_s = 1'b1;
               ret_state_d   = ST_RUN;
               state_d       = ST_MEM_WAIT;
            end else if (branch_taken) begin
               ifid_flush_s = 1'b1;
               idex_flush_s = 1'b1;
               state_d      = ST_RUN;
            end else if (hazard_s) begin
               pc_en_s      = 1'b0;
               ifid_en_s    = 1'b0;
               idex_flush_s = 1'b1;
               if (MULTI_STALL) begin
                  state_d     = ST_LD_STALL;
                  stall_cnt_d = STALL_RELOAD;
               end else begin
                  state_d     = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_LD_STALL: begin
            if (memstall_s) begin
               pc_en_s       = 1'b0;
               ifid_en_s     = 1'b0;
               exmem_en_s    = 1'b0;
               memwb_flush_s = 1'b1;
               ret_state_d   = ST_LD_STALL;
               state_d       = ST_MEM_WAIT;
            end else begin
               pc_en_s      = 1'b0;
               ifid_en_s    = 1'b0;
               idex_flush_s = 1'b1;
               if (stall_cnt_q <= 3'd1) begin
                  stall_cnt_d = 3'd0;
                  state_d     = ST_RUN;
               end else begin
                  stall_cnt_d = stall_cnt_q - 3'd1;
                  state_d     = ST_LD_STALL;
               end
            end
         end
         ST_MEM_WAIT: begin
            pc_en_s       = 1'b0;
            ifid_en_s     = 1'b0;
            exmem_en_s    = 1'b0;
            memwb_flush_s = 1'b1;
            state_d       = ST_MEM_WAIT;
         end
         default: begin
            state_d     = ST_RUN;
            ret_state_d = ST_RUN;
            stall_cnt_d = 3'd0;
         end
      endcase
   end

   // Operand forwarding selects, independent of stall state.
   always_comb begin
      fwd_a_s = fwd_sel(ex_rs);
      fwd_b_s = fwd_sel(ex_rt);
   end

   // Reset forces a safe frozen/flushed pipeline immediately.
   assign pc_en       = rst ? 1'b0  : pc_en_s;
   assign ifid_en     = rst ? 1'b0  : ifid_en_s;
   assign exmem_en    = rst ? 1'b0  : exmem_en_s;
   assign ifid_flush  = rst ? 1'b1  : ifid_flush_s;
   assign idex_flush  = rst ? 1'b1  : idex_flush_s;
   assign memwb_flush = rst ? 1'b1  : memwb_flush_s;
   assign fwd_a       = rst ? 2'b00 : fwd_a_s;
   assign fwd_b       = rst ? 2'b00 : fwd_b_s;

   // FSM state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         ret_state_q <= ST_RUN;
         stall_cnt_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         ret_state_q <= ret_state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cycles_q;
   logic [15:0] flush_events_q;

   // Saturating performance counters for stalled and flushed cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q <= 16'd0;
         flush_events_q <= 16'd0;
      end else begin
         if (!pc_en_s && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_q <= stall_cycles_q + 16'd1;
         end else begin
            stall_cycles_q <= stall_cycles_q;
         end
         if (ifid_flush_s && (flush_events_q != 16'hFFFF)) begin
            flush_events_q <= flush_events_q + 16'd1;
         end else begin
            flush_events_q <= flush_events_q;
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage 16-bit pipeline.
- Drives enable and flush (bubble) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC enable.
- Sequences load-use stalls, taken-branch flushes and multi-cycle data-memory waits with a small FSM.
- Produces EX-stage operand forwarding selects from the EX/MEM and MEM/WB destination fields (3-bit register numbers, WB control bit 1 = RegWrite).

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- ZERO_REG_HARDWIRED, 1, when 1 register 0 never causes a hazard or forward.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- id_rs  in  3  ID-stage source register A.
- id_rt  in  3  ID-stage source register B.
- id_uses_rs  in  1  ID instruction reads id_rs.
- id_uses_rt  in  1  ID instruction reads id_rt.
- ex_rs  in  3  EX-stage source A, for forwarding.
- ex_rt  in  3  EX-stage source B, for forwarding.
- ex_rd  in  3  EX-stage destination.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_mem_read  in  1  EX instruction is a load.
- branch_taken  in  1  branch resolved taken in EX.
- mem_rd  in  3  EX/MEM destination.
- mem_reg_write  in  1  EX/MEM RegWrite.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes this cycle.
- wb_rd  in  3  MEM/WB destination.
- wb_reg_write  in  1  MEM/WB RegWrite.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_flush  out  1  ID/EX loads a bubble (control zeroed).
- exmem_en  out  1  EX/MEM load enable.
- memwb_flush  out  1  MEM/WB loads WB=2'b00.
- fwd_a  out  2  EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- fwd_b  out  2  EX operand B source, same encoding.

Behaviour:
- State register: state (RUN, LD_STALL, MEM_WAIT), ret_state, stall_cnt[2:0].
- Async reset (rst high, at any time including mid-stall or mid-wait) sets state=RUN and stall_cnt=0, and clears the optional counters.
- Outputs while rst is high: pc_en=0, ifid_en=0, exmem_en=0, ifid_flush=1, idex_flush=1, memwb_flush=1, fwd_a=fwd_b=00.
- Control outputs are combinational from state and current inputs, so they take effect in the same cycle. State updates on posedge clk.
- Match rule: a register r matches when it is equal to the compared register. If ZERO_REG_HARDWIRED=1, r must also be non-zero.
- hazard = ex_mem_read & ex_reg_write & ((id_uses_rs & match(id_rs,ex_rd)) | (id_uses_rt & match(id_rt,ex_rd))).
- memstall = mem_req & ~mem_ready.
- Priority: memstall > branch_taken > hazard.
- RUN, default outputs: pc_en=1, ifid_en=1, exmem_en=1, all flushes 0.
- RUN with memstall:
  - pc_en, ifid_en and exmem_en are 0. ID/EX is held by idex_flush=0 together with the frozen front end. memwb_flush=1.
  - ret_state=RUN, next state MEM_WAIT.
- RUN with branch_taken and no memstall: ifid_flush=1, idex_flush=1. Any hazard is ignored. State stays RUN.
- RUN with hazard only:
  - pc_en=0, ifid_en=0, idex_flush=1.
  - If LOAD_STALL_CYCLES>1, next state is LD_STALL with stall_cnt=LOAD_STALL_CYCLES-1.
- LD_STALL: outputs as for a hazard stall. stall_cnt decrements each cycle. At stall_cnt==1 the next state is RUN.
- LD_STALL with memstall: MEM_WAIT outputs apply, stall_cnt is frozen, ret_state=LD_STALL.
- MEM_WAIT: outputs as for RUN with memstall. When mem_ready=1, that cycle's outputs are the ret_state outputs and next state is ret_state.
- A branch_taken held across MEM_WAIT is acted on in the first non-stalled cycle.
- fwd_a:
  - 01 if mem_reg_write & match(ex_rs,mem_rd).
  - Otherwise 10 if wb_reg_write & match(ex_rs,wb_rd).
  - Otherwise 00.
  - EX/MEM has priority on a double match.
- fwd_b: same rule using ex_rt.
- During MEM_WAIT, forwarding is computed unchanged.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds output ports stall_cycles[15:0] and flush_events[15:0], both reset to 0 and saturating at 16'hFFFF.
  - stall_cycles increments every clk where pc_en=0 and rst=0.
  - flush_events increments every clk where ifid_flush=1 and rst=0.
- When undefined, these ports and their registers are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-LD_STALL (LOAD_STALL_CYCLES=3) -> outputs immediately take the reset values. After release, state=RUN, pc_en=1, flushes 0.
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=3, id_rs=3, id_uses_rs=1 -> exactly LOAD_STALL_CYCLES cycles of pc_en=0 and idex_flush=1. Then pc_en=1.
- R0: same stimulus with ex_rd=0, id_rs=0 and ZERO_REG_HARDWIRED=1 -> no stall. Forwarding stays 00 for mem_rd=0.
- Branch vs hazard: branch_taken=1 in the same cycle as a load-use hazard -> ifid_flush=1, idex_flush=1, pc_en=1, no LD_STALL entry.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then 1 -> 4 cycles of pc_en=ifid_en=exmem_en=0 with memwb_flush=1. Normal flow on the ready cycle. With the macro defined, stall_cycles=4.
- Forwarding: ex_rs=5, mem_rd=5, wb_rd=5, both RegWrite=1 -> fwd_a=01. Clearing mem_reg_write -> fwd_a=10. Setting ex_rt=2 with no matching destination -> fwd_b=00.
